// File: rtl/wired_pcgen_nw.sv
// wired_pcgen_nw: N-wide fetch-block PC generator with BTB/PHT/RAS next-PC prediction.
// Latency: prediction is combinational from the pc register; table training is visible next cycle.
// Backpressure: !p_ready_i freezes pc and RAS state; redirect_i drops p_valid_o and reloads pc.
module wired_pcgen_nw #(
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned BTB_DEPTH   = 64,
  parameter int unsigned TAG_WIDTH   = 7,
  parameter int unsigned PHT_DEPTH   = 64,
  parameter int unsigned RAS_DEPTH   = 8,
  parameter logic [31:0] RESET_PC    = 32'h1c000000,
  localparam int unsigned RPW        = $clog2(RAS_DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   upd_valid_i,
  input  logic [31:0]            upd_pc_i,
  input  logic [2:0]             upd_type_i,
  input  logic                   upd_taken_i,
  input  logic [31:0]            upd_target_i,
  input  logic                   redirect_i,
  input  logic [31:0]            redirect_pc_i,
  input  logic [RPW-1:0]         redirect_ras_ptr_i,
  input  logic                   p_ready_i,
  output logic                   p_valid_o,
  output logic [31:0]            p_pc_o,
  output logic [FETCH_WIDTH-1:0] p_mask_o,
  output logic [FETCH_WIDTH-1:0] p_taken_o,
  output logic [31:0]            p_npc_o,
  output logic [RPW-1:0]         p_ras_ptr_o
);

  localparam int unsigned LW   = $clog2(FETCH_WIDTH);
  localparam int unsigned OFF  = LW + 2;
  localparam int unsigned IDXW = $clog2(BTB_DEPTH);
  localparam int unsigned PHTW = $clog2(PHT_DEPTH);

  localparam logic [2:0] T_NONE = 3'b000;
  localparam logic [2:0] T_COND = 3'b001;
  localparam logic [2:0] T_JUMP = 3'b010;
  localparam logic [2:0] T_CALL = 3'b011;
  localparam logic [2:0] T_RET  = 3'b100;

  // Prediction tables: one BTB bank per lane, shared PHT, circular RAS.
  logic                 btb_vld_q  [FETCH_WIDTH][BTB_DEPTH];
  logic [TAG_WIDTH-1:0] btb_tag_q  [FETCH_WIDTH][BTB_DEPTH];
  logic [2:0]           btb_type_q [FETCH_WIDTH][BTB_DEPTH];
  logic [29:0]          btb_tgt_q  [FETCH_WIDTH][BTB_DEPTH];
  logic [1:0]           pht_q      [PHT_DEPTH];
  logic [31:0]          ras_q      [RAS_DEPTH];

  logic [31:0]    pc_q, pc_d;
  logic [RPW-1:0] ras_ptr_q, ras_ptr_d;

  logic [31:0]           base;
  logic [LW-1:0]         off;
  logic [IDXW-1:0]       lk_idx;
  logic [TAG_WIDTH-1:0]  lk_tag;
  logic [PHTW-1:0]       lane_phti;
  logic                  lane_hit;
  logic [2:0]            lane_type;
  logic                  found;
  logic [LW-1:0]         tsel;
  logic [2:0]            tsel_type;
  logic                  accept;
  logic                  ras_we;
  logic [RPW-1:0]        ras_wa;
  logic [31:0]           ras_wd;

  // Training-side decode of the update PC.
  logic [LW-1:0]         upd_lane;
  logic [IDXW-1:0]       upd_idx;
  logic [TAG_WIDTH-1:0]  upd_tag;
  logic [PHTW-1:0]       upd_phti;
  logic                  unused_tgt_lsb;

  assign upd_lane       = upd_pc_i[OFF-1:2];
  assign upd_idx        = upd_pc_i[OFF+IDXW-1:OFF];
  assign upd_tag        = upd_pc_i[OFF+IDXW+TAG_WIDTH-1:OFF+IDXW];
  assign upd_phti       = upd_pc_i[PHTW+1:2];
  assign unused_tgt_lsb = ^upd_target_i[1:0];

  assign p_valid_o   = rst_n && !redirect_i;
  assign p_pc_o      = pc_q;
  assign p_ras_ptr_o = ras_ptr_q;
  assign accept      = p_valid_o && p_ready_i;

  // Lane lookup, lowest-taken-lane select, mask and next-PC prediction.
  always_comb begin
    base      = {pc_q[31:OFF], {OFF{1'b0}}};
    off       = pc_q[OFF-1:2];
    lk_idx    = pc_q[OFF+IDXW-1:OFF];
    lk_tag    = pc_q[OFF+IDXW+TAG_WIDTH-1:OFF+IDXW];
    lane_phti = '0;
    lane_hit  = 1'b0;
    lane_type = T_NONE;
    found     = 1'b0;
    tsel      = '0;
    p_taken_o = '0;
    p_mask_o  = '0;
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      lane_phti = PHTW'((base >> 2) + 32'(i));
      lane_type = btb_type_q[i][lk_idx];
      lane_hit  = btb_vld_q[i][lk_idx] && (btb_tag_q[i][lk_idx] == lk_tag) && (LW'(i) >= off);
      if (!found && lane_hit &&
          ((lane_type == T_JUMP) || (lane_type == T_CALL) || (lane_type == T_RET) ||
           ((lane_type == T_COND) && pht_q[lane_phti][1]))) begin
        found = 1'b1;
        tsel  = LW'(i);
      end
    end
    for (int i = 0; i < FETCH_WIDTH; i++) begin
      p_mask_o[i] = (LW'(i) >= off) && (!found || (LW'(i) <= tsel));
    end
    tsel_type = btb_type_q[tsel][lk_idx];
    if (found) begin
      p_taken_o[tsel] = 1'b1;
    end
    if (!found) begin
      p_npc_o = base + 32'(4 * FETCH_WIDTH);
    end else if (tsel_type == T_RET) begin
      p_npc_o = ras_q[ras_ptr_q];
    end else begin
      p_npc_o = {btb_tgt_q[tsel][lk_idx], 2'b00};
    end
  end

  // Next pc and RAS pointer: redirect repair wins over speculative push/pop.
  always_comb begin
    pc_d      = pc_q;
    ras_ptr_d = ras_ptr_q;
    ras_we    = 1'b0;
    ras_wa    = ras_ptr_q + RPW'(1);
    ras_wd    = base + 32'({tsel, 2'b00}) + 32'd4;
    if (redirect_i) begin
      pc_d = redirect_pc_i;
      if (upd_valid_i && (upd_type_i == T_CALL)) begin
        ras_ptr_d = redirect_ras_ptr_i + RPW'(1);
        ras_we    = 1'b1;
        ras_wa    = redirect_ras_ptr_i + RPW'(1);
        ras_wd    = upd_pc_i + 32'd4;
      end else if (upd_valid_i && (upd_type_i == T_RET)) begin
        ras_ptr_d = redirect_ras_ptr_i - RPW'(1);
      end else begin
        ras_ptr_d = redirect_ras_ptr_i;
      end
    end else if (accept) begin
      pc_d = p_npc_o;
      if (found && (tsel_type == T_CALL)) begin
        ras_we    = 1'b1;
        ras_ptr_d = ras_ptr_q + RPW'(1);
      end else if (found && (tsel_type == T_RET)) begin
        ras_ptr_d = ras_ptr_q - RPW'(1);
      end
    end
  end

  // pc and RAS pointer registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q      <= RESET_PC;
      ras_ptr_q <= '0;
    end else begin
      pc_q      <= pc_d;
      ras_ptr_q <= ras_ptr_d;
    end
  end

  // RAS storage: single write port shared by push and call repair.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 0; r < RAS_DEPTH; r++) ras_q[r] <= '0;
    end else if (ras_we) begin
      ras_q[ras_wa] <= ras_wd;
    end
  end

  // BTB training: NONE invalidates, any other type installs the entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int l = 0; l < FETCH_WIDTH; l++) begin
        for (int e = 0; e < BTB_DEPTH; e++) begin
          btb_vld_q[l][e]  <= 1'b0;
          btb_tag_q[l][e]  <= '0;
          btb_type_q[l][e] <= T_NONE;
          btb_tgt_q[l][e]  <= '0;
        end
      end
    end else if (upd_valid_i) begin
      if (upd_type_i == T_NONE) begin
        btb_vld_q[upd_lane][upd_idx] <= 1'b0;
      end else begin
        btb_vld_q[upd_lane][upd_idx]  <= 1'b1;
        btb_tag_q[upd_lane][upd_idx]  <= upd_tag;
        btb_type_q[upd_lane][upd_idx] <= upd_type_i;
        btb_tgt_q[upd_lane][upd_idx]  <= upd_target_i[31:2];
      end
    end
  end

  // PHT training: saturating bimodal counters, weakly not-taken at reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int p = 0; p < PHT_DEPTH; p++) pht_q[p] <= 2'b01;
    end else if (upd_valid_i && (upd_type_i == T_COND)) begin
      if (upd_taken_i && (pht_q[upd_phti] != 2'b11)) begin
        pht_q[upd_phti] <= pht_q[upd_phti] + 2'b01;
      end else if (!upd_taken_i && (pht_q[upd_phti] != 2'b00)) begin
        pht_q[upd_phti] <= pht_q[upd_phti] - 2'b01;
      end
    end
  end

endmodule

// File: doc/wired_pcgen_nw.md
Name: wired_pcgen_nw

Overview:
N-wide fetch-block PC generator with single-cycle next-PC prediction. It is a parametrised successor of the two-lane PC gen, generalised in fetch width, BTB/PHT depth, tag width and RAS depth. It adds an unconditional-jump type, BTB entry invalidation, saturating bimodal counters and RAS repair on call/return mispredicts. It sits ahead of the I-cache: it issues one aligned fetch block per accepted handshake and receives training and redirects from the backend.

Parameters:
FETCH_WIDTH, 2, instructions per fetch block; power of 2 in 2..8; OFF = log2(FETCH_WIDTH)+2.
BTB_DEPTH, 64, BTB entries per lane; power of 2; IDXW = log2(BTB_DEPTH).
TAG_WIDTH, 7, BTB tag bits, taken from pc[OFF+IDXW+TAG_WIDTH-1 : OFF+IDXW].
PHT_DEPTH, 64, 2-bit counters; power of 2; indexed by pc[log2(PHT_DEPTH)+1:2].
RAS_DEPTH, 8, return address stack entries; power of 2; RPW = log2(RAS_DEPTH).
RESET_PC, 32'h1c000000, PC after reset.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
upd_valid_i  in  1  training update strobe
upd_pc_i  in  32  PC of the trained instruction
upd_type_i  in  3  type: 000 NONE, 001 COND, 010 JUMP, 011 CALL, 100 RETURN
upd_taken_i  in  1  resolved direction (COND only)
upd_target_i  in  32  resolved target
redirect_i  in  1  backend redirect
redirect_pc_i  in  32  redirect PC
redirect_ras_ptr_i  in  RPW  p_ras_ptr_o of the mispredicted block
p_ready_i  in  1  consumer ready
p_valid_o  out  1  fetch block valid
p_pc_o  out  32  fetch PC (may be unaligned)
p_mask_o  out  FETCH_WIDTH  valid lanes
p_taken_o  out  FETCH_WIDTH  one-hot predicted-taken lane, or zero
p_npc_o  out  32  predicted next PC
p_ras_ptr_o  out  RPW  RAS pointer before this block's push or pop

Behaviour:
- Reset values: pc=RESET_PC, ras_ptr=0, all BTB valid=0, all PHT=2'b01, RAS contents 0.
- While rst_n is low, p_valid_o=0. Other outputs follow combinationally from the reset state.
- p_valid_o = !redirect_i.
- The pc register advances to p_npc_o when p_valid_o && p_ready_i.
- On redirect_i, pc <= redirect_pc_i irrespective of p_ready_i. Redirect has priority over any accept.
- When p_valid_o && !p_ready_i, all outputs hold stable.
- Lane and base: base = {pc[31:OFF], OFF'b0}; lane i is at base + 4i; off = pc[OFF-1:2].
- BTB lookup: lane i reads entry[i][pc[OFF+IDXW-1:OFF]]; hit = valid && tag match && i >= off.
- Lane taken conditions:
  - type JUMP, CALL or RETURN with a hit;
  - type COND with a hit and PHT[lane pc][1] = 1.
- The lowest taken lane t sets p_taken_o[t]=1.
- p_mask_o covers lanes off..t, or off..FETCH_WIDTH-1 when no lane is taken.
- p_npc_o:
  - RAS[ras_ptr] when lane t is RETURN;
  - the BTB target when lane t is any other taken type;
  - base + 4*FETCH_WIDTH when no lane is taken.
- The prediction path is purely combinational from pc and the tables: zero-cycle latency, no SRAM.
- RAS push, on accept with a taken CALL: RAS[ras_ptr+1] <= base+4t+4; ras_ptr++. Wraps modulo RAS_DEPTH, overwriting the oldest entry silently.
- RAS pop, on accept with a taken RETURN: ras_ptr--. Wraps; no underflow flag.
- RAS repair on redirect_i:
  - with upd_valid_i and CALL: ras_ptr <= redirect_ras_ptr_i+1 and RAS[that] <= upd_pc_i+4;
  - with upd_valid_i and RETURN: ras_ptr <= redirect_ras_ptr_i-1;
  - otherwise: ras_ptr <= redirect_ras_ptr_i.
  - Repair overrides any speculative push or pop in the same cycle.
- BTB training on upd_valid_i: lane = upd_pc_i[OFF-1:2]; index and tag come from upd_pc_i.
  - type NONE clears valid;
  - any other type writes {valid=1, tag, type, upd_target_i[31:2]}.
- PHT training on upd_valid_i with COND: saturating +1 if upd_taken_i, else -1 (range 00..11).
- A training write is visible from the next cycle. A same-cycle lookup of the same entry sees the old value.
- All arithmetic is 32-bit wrapping. Targets are word aligned, bits [1:0]=0.

Test Plan:
All scenarios use default parameters and keep p_ready_i=1 unless stated.
- Reset: release rst_n -> p_pc_o=0x1c000000, mask=2'b11, taken=0, npc=0x1c000008, then 0x1c000010 on consecutive cycles.
- Unaligned redirect to 0x1c000104 -> p_valid_o=0 that cycle; next cycle p_pc_o=0x1c000104, mask=2'b10, npc=0x1c000108.
- JUMP train at 0x1c000010, target 0x1c000400 -> at pc=0x1c000010: taken=2'b01, mask=2'b01, npc=0x1c000400.
- NONE train at the same PC -> fall-through, npc=0x1c000018.
- COND at 0x1c000014:
  - one taken update (01->10) -> taken=2'b10, npc=target;
  - two not-taken updates (->00) -> not taken;
  - four taken updates -> saturates at 11.
- RAS:
  - CALL at 0x1c000020 (lane0) with target 0x1c000800, RETURN at 0x1c000800 -> return block npc=0x1c000024;
  - 9 nested calls -> ras_ptr wraps to 1 and the oldest entry is overwritten.
- p_ready_i=0 for 3 cycles -> outputs frozen; redirect_i during the stall -> p_valid_o=0 and the redirect target is output next.
- Redirect with CALL update at 0x1c000030 and redirect_ras_ptr_i=3 -> ras_ptr=4, RAS[4]=0x1c000034.
